seven_seg_capture: RTL and testbench

- Observes the multiplexed Basys3 display bus (`cathod` digit strobes and `led_code` segments) as driven by `seven_seg`, and reconstructs the four hex digits.
- Publishes a complete frame with a one-cycle valid pulse.
- Used as the read-back end of the display interface: self-check logic in integration, and a scoreboard front-end on benches.

---
 rtl/seven_seg_capture_if.sv | 9 +
 rtl/seven_seg_capture.sv | 210 +++++++++++++++++++++
 tb/tb_seven_seg_capture.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/seven_seg_capture_if.sv
// seven_seg_capture_if: multiplexed Basys3 display bus (digit strobes plus segments).
// The master drives the display and the slave observes it. Both strobes and segments are active-low.
interface seven_seg_capture_if;
   logic [3:0] cathod;
   logic [7:0] led_code;

   modport master (output cathod, output led_code);
   modport slave  (input  cathod, input  led_code);
endinterface

// File: rtl/seven_seg_capture.sv
// seven_seg_capture: reconstructs the four hex digits from the multiplexed seven-segment bus.
// It publishes each complete frame with a one-cycle frame_valid pulse.
// Optional macro SEVSEG_CAPTURE_DP_EN adds the dp[3:0] output, which captures the decimal points.
module seven_seg_capture #(
   parameter int unsigned STABLE_CYCLES  = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic                      clock,
   input  logic                      reset,
   seven_seg_capture_if.slave        bus,
   output logic [3:0]                dig0,
   output logic [3:0]                dig1,
   output logic [3:0]                dig2,
   output logic [3:0]                dig3,
   output logic                      frame_valid,
   output logic                      frame_err,
   output logic                      stale
`ifdef SEVSEG_CAPTURE_DP_EN
   ,
   output logic [3:0]                dp
`endif
);

`ifdef SEVSEG_CAPTURE_DP_EN
   localparam int unsigned SEG_W = 8;
`else
   localparam int unsigned SEG_W = 7;
`endif
   localparam int unsigned SCW = $clog2(STABLE_CYCLES + 1);
   localparam int unsigned TCW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [SCW-1:0] STABLE_MAX  = SCW'(STABLE_CYCLES);
   localparam logic [TCW-1:0] TIMEOUT_MAX = TCW'(TIMEOUT_CYCLES);

   logic [3:0]       s_cath_q, s_cath_d;
   logic [SEG_W-1:0] s_seg_q, s_seg_d;
   logic [SCW-1:0]   stab_cnt_q, stab_cnt_d;
   logic             captured_q, captured_d;
   logic [3:0][3:0]  slot_val_q, slot_val_d;
   logic [3:0]       slot_err_q, slot_err_d;
   logic [3:0]       seen_q, seen_d;
   logic [TCW-1:0]   tout_cnt_q, tout_cnt_d;
   logic             stale_q, stale_d;
   logic [3:0][3:0]  dig_q, dig_d;
   logic             frame_valid_q, frame_valid_d;
   logic             frame_err_q, frame_err_d;
`ifdef SEVSEG_CAPTURE_DP_EN
   logic [3:0]       slot_dp_q, slot_dp_d;
   logic [3:0]       dp_q, dp_d;
`endif

   logic             change;
   logic             slot_hit;
   logic [1:0]       slot_idx;
   logic             capture;
   logic             publish;
   logic [4:0]       dec;

   // Segment decode: returns {illegal, value}. An illegal pattern decodes to 0.
   function automatic logic [4:0] decode(input logic [6:0] seg_n);
      logic [6:0] p;
      p = ~seg_n;
      case (p)
         7'h3F:   decode = 5'h00;
         7'h06:   decode = 5'h01;
         7'h5B:   decode = 5'h02;
         7'h4F:   decode = 5'h03;
         7'h66:   decode = 5'h04;
         7'h6D:   decode = 5'h05;
         7'h7D:   decode = 5'h06;
         7'h07:   decode = 5'h07;
         7'h7F:   decode = 5'h08;
         7'h6F:   decode = 5'h09;
         7'h77:   decode = 5'h0A;
         7'h7C:   decode = 5'h0B;
         7'h39:   decode = 5'h0C;
         7'h5E:   decode = 5'h0D;
         7'h79:   decode = 5'h0E;
         7'h71:   decode = 5'h0F;
         default: decode = 5'h10;
      endcase
   endfunction

   // Next-state logic: input stage, dwell counter, capture, frame publish and timeout.
   always_comb begin
      s_cath_d      = bus.cathod;
      s_seg_d       = bus.led_code[SEG_W-1:0];
      slot_val_d    = slot_val_q;
      slot_err_d    = slot_err_q;
      seen_d        = seen_q;
      tout_cnt_d    = tout_cnt_q;
      stale_d       = stale_q;
      dig_d         = dig_q;
      frame_valid_d = 1'b0;
      frame_err_d   = frame_err_q;
`ifdef SEVSEG_CAPTURE_DP_EN
      slot_dp_d     = slot_dp_q;
      dp_d          = dp_q;
`endif

      // The incoming bus is compared with the registered copy, so stab_cnt_q
      // counts how many cycles the registered value {s_cath_q, s_seg_q} has held.
      change = ({bus.cathod, bus.led_code[SEG_W-1:0]} != {s_cath_q, s_seg_q});
      if (change)
         stab_cnt_d = SCW'(1);
      else if (stab_cnt_q == STABLE_MAX)
         stab_cnt_d = stab_cnt_q;
      else
         stab_cnt_d = stab_cnt_q + 1'b1;

      slot_hit = 1'b1;
      slot_idx = 2'd0;
      case (s_cath_q)
         4'b1110: slot_idx = 2'd0;
         4'b1101: slot_idx = 2'd1;
         4'b1011: slot_idx = 2'd2;
         4'b0111: slot_idx = 2'd3;
         default: slot_hit = 1'b0;
      endcase

      capture    = slot_hit && (stab_cnt_q == STABLE_MAX) && !captured_q;
      // A change starts a new dwell. A capture on the same edge belongs to the old dwell.
      captured_d = change ? 1'b0 : (capture ? 1'b1 : captured_q);
      dec        = decode(s_seg_q[6:0]);
      publish    = (seen_q == 4'hF);

      if (publish) begin
         dig_d         = slot_val_q;
         frame_err_d   = |slot_err_q;
         frame_valid_d = 1'b1;
         stale_d       = 1'b0;
         seen_d        = '0;
         slot_err_d    = '0;
`ifdef SEVSEG_CAPTURE_DP_EN
         dp_d          = slot_dp_q;
`endif
      end

      if (capture || publish) begin
         tout_cnt_d = '0;
      end else if (tout_cnt_q != TIMEOUT_MAX) begin
         tout_cnt_d = tout_cnt_q + 1'b1;
         if (tout_cnt_d == TIMEOUT_MAX) begin
            seen_d     = '0;
            slot_err_d = '0;
            stale_d    = 1'b1;
         end
      end

      // A capture is applied after publish, so it lands in the freshly cleared seen vector.
      if (capture) begin
         slot_val_d[slot_idx] = dec[3:0];
         slot_err_d[slot_idx] = dec[4];
         seen_d[slot_idx]     = 1'b1;
`ifdef SEVSEG_CAPTURE_DP_EN
         slot_dp_d[slot_idx]  = ~s_seg_q[7];
`endif
      end
   end

   // State registers, cleared by the asynchronous active-low reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         s_cath_q      <= '0;
         s_seg_q       <= '0;
         stab_cnt_q    <= '0;
         captured_q    <= 1'b0;
         slot_val_q    <= '0;
         slot_err_q    <= '0;
         seen_q        <= '0;
         tout_cnt_q    <= '0;
         stale_q       <= 1'b0;
         dig_q         <= '0;
         frame_valid_q <= 1'b0;
         frame_err_q   <= 1'b0;
`ifdef SEVSEG_CAPTURE_DP_EN
         slot_dp_q     <= '0;
         dp_q          <= '0;
`endif
      end else begin
         s_cath_q      <= s_cath_d;
         s_seg_q       <= s_seg_d;
         stab_cnt_q    <= stab_cnt_d;
         captured_q    <= captured_d;
         slot_val_q    <= slot_val_d;
         slot_err_q    <= slot_err_d;
         seen_q        <= seen_d;
         tout_cnt_q    <= tout_cnt_d;
         stale_q       <= stale_d;
         dig_q         <= dig_d;
         frame_valid_q <= frame_valid_d;
         frame_err_q   <= frame_err_d;
`ifdef SEVSEG_CAPTURE_DP_EN
         slot_dp_q     <= slot_dp_d;
         dp_q          <= dp_d;
`endif
      end
   end

   assign dig0        = dig_q[0];
   assign dig1        = dig_q[1];
   assign dig2        = dig_q[2];
   assign dig3        = dig_q[3];
   assign frame_valid = frame_valid_q;
   assign frame_err   = frame_err_q;
   assign stale       = stale_q;
`ifdef SEVSEG_CAPTURE_DP_EN
   assign dp          = dp_q;
`endif

endmodule

// File: tb/tb_seven_seg_capture.sv
// tb_seven_seg_capture: scoreboard bench for seven_seg_capture (STABLE_CYCLES=4, TIMEOUT_CYCLES=50).
// The drive tasks model slot capture and push each expected frame. A negedge monitor pops and checks it.
module tb_seven_seg_capture;
   localparam int unsigned STABLE = 4;
   localparam int unsigned TMO    = 50;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] dig0, dig1, dig2, dig3;
   logic       frame_valid, frame_err, stale;
`ifdef SEVSEG_CAPTURE_DP_EN
   logic [3:0] dp;
`endif

   seven_seg_capture_if bus();

   seven_seg_capture #(
      .STABLE_CYCLES (STABLE),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .bus        (bus),
      .dig0       (dig0),
      .dig1       (dig1),
      .dig2       (dig2),
      .dig3       (dig3),
      .frame_valid(frame_valid),
      .frame_err  (frame_err),
      .stale      (stale)
`ifdef SEVSEG_CAPTURE_DP_EN
      ,
      .dp         (dp)
`endif
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   typedef struct {
      logic [15:0] digs;
      logic        err;
      int          cyc;
   } exp_t;
   exp_t exp_q[$];

   logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   // Reference model state.
   logic [3:0]  m_val [4];
   logic [3:0]  m_err;
   logic [3:0]  m_seen;
   logic        m_stale;
   logic        m_tmo;
   logic [15:0] m_pub;
   int          last_cap;

   task automatic model_clear();
      for (int i = 0; i < 4; i++) m_val[i] = '0;
      m_err    = '0;
      m_seen   = '0;
      m_stale  = 1'b0;
      m_tmo    = 1'b0;
      m_pub    = '0;
      last_cap = cyc;
   endtask

   task automatic apply_timeout(input int e);
      if (!m_tmo && (e - last_cap) >= int'(TMO)) begin
         m_seen  = '0;
         m_err   = '0;
         m_stale = 1'b1;
         m_tmo   = 1'b1;
      end
   endtask

   // Holds one bus value for n cycles, starting at a negedge, and updates the model.
   task automatic dwell(input logic [3:0] cath, input logic [7:0] led, input int n,
                        input logic [3:0] ev, input logic ee);
      int   c0, slot, cc;
      exp_t e;
      bus.cathod   = cath;
      bus.led_code = led;
      c0   = cyc;
      slot = -1;
      case (cath)
         4'b1110: slot = 0;
         4'b1101: slot = 1;
         4'b1011: slot = 2;
         4'b0111: slot = 3;
         default: slot = -1;
      endcase
      if (slot >= 0 && n >= int'(STABLE)) begin
         cc = c0 + int'(STABLE) + 1;
         apply_timeout(cc - 1);
         m_val[slot]  = ev;
         m_err[slot]  = ee;
         m_seen[slot] = 1'b1;
         last_cap     = cc;
         m_tmo        = 1'b0;
         if (m_seen == 4'hF) begin
            e.digs = {m_val[3], m_val[2], m_val[1], m_val[0]};
            e.err  = |m_err;
            e.cyc  = cc + 1;
            exp_q.push_back(e);
            m_pub    = e.digs;
            m_seen   = '0;
            m_err    = '0;
            m_stale  = 1'b0;
            last_cap = cc + 1;
         end
      end
      repeat (n) @(negedge clock);
   endtask

   task automatic digit(input int slot, input int v, input int n);
      logic [3:0] c;
      logic [3:0] vv;
      c  = 4'b0001 << slot;
      vv = 4'(v);
      dwell(~c, {1'b1, ~seg_tab[v]}, n, vv, 1'b0);
   endtask

   task automatic scan(input int a, input int b, input int c, input int d, input int n);
      digit(0, a, n);
      digit(1, b, n);
      digit(2, c, n);
      digit(3, d, n);
   endtask

   task automatic do_reset(input int n);
      reset = 1'b0;
      repeat (n) begin
         bus.cathod   = 4'($urandom);
         bus.led_code = 8'($urandom);
         @(negedge clock);
      end
      bus.cathod   = 4'hF;
      bus.led_code = 8'hFF;
      reset = 1'b1;
      model_clear();
   endtask

   // Monitor: every frame_valid must match the oldest expected frame, including its arrival cycle.
   always @(negedge clock) begin : mon
      exp_t e;
      if (frame_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_frame", 32'(frame_valid), 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("frame_digs", 32'({dig3, dig2, dig1, dig0}), 32'(e.digs));
            check("frame_err", 32'(frame_err), 32'(e.err));
            check("frame_stale", 32'(stale), 32'd0);
            check("frame_latency", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   initial begin
      bus.cathod   = 4'hF;
      bus.led_code = 8'hFF;
      model_clear();
      @(negedge clock);

      // Reset held with the bus toggling.
      do_reset(10);
      check("rst_digs", 32'({dig3, dig2, dig1, dig0}), 32'd0);
      check("rst_flags", 32'({frame_valid, frame_err, stale}), 32'd0);
      repeat (5) @(negedge clock);
      check("post_rst_digs", 32'({dig3, dig2, dig1, dig0}), 32'd0);
      check("post_rst_flags", 32'({frame_valid, frame_err, stale}), 32'd0);

      // Nominal scan: cathod E/D/B/7 with led_code C0/F9/A4/B0.
      scan(0, 1, 2, 3, 8);
      repeat (2) @(negedge clock);
      check("nominal_hold", 32'({dig3, dig2, dig1, dig0}), 32'(m_pub));

      // Glitch: a 3-cycle dig1 dwell is not captured.
      digit(0, 4, 8);
      digit(1, 5, 3);
      digit(2, 6, 8);
      digit(3, 7, 8);
      check("glitch_no_frame", 32'(exp_q.size()), 32'd0);
      digit(1, 5, 8);

      // Dwells of exactly STABLE_CYCLES are captured.
      scan(8, 9, 10, 11, int'(STABLE));

      // An illegal pattern in slot 2 decodes to 0 and sets frame_err.
      digit(0, 12, 8);
      digit(1, 13, 8);
      dwell(4'b1011, 8'hFF, 8, 4'h0, 1'b1);
      digit(3, 15, 8);

      // Blanking and overlap between digits, plus a recapture of slot 0.
      digit(0, 9, 8);
      dwell(4'hF, 8'hFF, 20, 4'h0, 1'b0);
      digit(0, 1, 8);
      dwell(4'hC, 8'hC0, 20, 4'h0, 1'b0);
      digit(1, 2, 8);
      dwell(4'hF, 8'hC0, 20, 4'h0, 1'b0);
      digit(2, 3, 8);
      dwell(4'hC, 8'hF9, 20, 4'h0, 1'b0);
      digit(3, 4, 8);
      repeat (4) @(negedge clock);

      // Timeout: the partial frame is discarded, stale asserts and the digits are kept.
      digit(0, 5, 8);
      digit(1, 6, 8);
      dwell(4'hF, 8'hFF, 60, 4'h0, 1'b0);
      apply_timeout(cyc);
      check("stale_set", 32'(stale), 32'(m_stale));
      check("tmo_digs_kept", 32'({dig3, dig2, dig1, dig0}), 32'(m_pub));
      digit(2, 7, 8);
      digit(3, 8, 8);
      dwell(4'hF, 8'hFF, 10, 4'h0, 1'b0);
      check("tmo_no_frame", 32'(exp_q.size()), 32'd0);
      check("stale_hold", 32'(stale), 32'(m_stale));
      scan(9, 10, 11, 12, 8);
      check("stale_clr", 32'(stale), 32'(m_stale));

      // Reset mid-frame discards the slots captured before it.
      digit(0, 3, 8);
      do_reset(3);
      check("midrst_flags", 32'({frame_valid, frame_err, stale}), 32'd0);
      check("midrst_digs", 32'({dig3, dig2, dig1, dig0}), 32'd0);
      digit(3, 5, 8);
      dwell(4'hF, 8'hFF, 10, 4'h0, 1'b0);
      check("midrst_no_frame", 32'(exp_q.size()), 32'd0);
      scan(6, 7, 8, 9, 8);

      dwell(4'hF, 8'hFF, 20, 4'h0, 1'b0);
      check("sb_drain", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
